// File: rtl/mem_pkg.sv
// Shared definitions for the block-copy engine: bus widths, the word
// stride in bytes and the sequencer state encoding.
package mem_pkg;

    // Byte address width of the data memory (64 KiB).
    localparam int AW = 16;

    // Width of one memory word.
    localparam int DW = 16;

    // Width of the word-count input.
    localparam int LW = 16;

    // Distance in bytes between consecutive words.
    localparam int WORD_BYTES = DW / 8;

    // Sequencer states: each word costs one READ and one WRITE cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_copy_if.sv
// Bundle of the core-facing control signals and the memory read/write
// port of the copy engine. The engine uses the master view; the core
// and memory side use the slave view.
interface mem_copy_if;
    import mem_pkg::*;

    logic          start;
    logic          abort;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    modport master (
        input  start, abort, src, dst, len, rdata,
        output busy, done, raddr, wen, waddr, wdata
    );

    modport slave (
        output start, abort, src, dst, len, rdata,
        input  busy, done, raddr, wen, waddr, wdata
    );

endinterface

// File: rtl/mem_copy_dir.sv
// Copy-direction decision and starting addresses for a new request.
// A copy must run top-down when the destination begins inside the
// source block (measured forward from src, modulo the address space);
// otherwise bottom-up is safe. Top-down starts at the last word of each
// block. All arithmetic wraps at the top of the address space.
module mem_copy_dir
    import mem_pkg::*;
(
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [LW-1:0] len,
    output logic          desc,
    output logic [AW-1:0] start_src,
    output logic [AW-1:0] start_dst
);

    logic [LW:0]   len_bytes;
    logic [AW:0]   span;
    logic [AW-1:0] diff;
    logic [LW-1:0] len_m1;
    logic [LW:0]   last_bytes;
    logic [AW-1:0] last_off;

    // Overlap test on the forward distance dst-src against the block
    // size in bytes (one extra bit so a full-size block still compares),
    // then pick the first word pair to move.
    always_comb begin
        len_bytes  = {len, 1'b0};
        span       = (AW+1)'(len_bytes);
        diff       = dst - src;
        desc       = (dst != src) && ({1'b0, diff} < span);
        len_m1     = len - LW'(1);
        last_bytes = {len_m1, 1'b0};
        last_off   = AW'(last_bytes);
        start_src  = desc ? (src + last_off) : src;
        start_dst  = desc ? (dst + last_off) : dst;
    end

endmodule

// File: rtl/mem_copy.sv
// Block-copy bus initiator. Moves len 16-bit words from src to dst in
// the byte-addressed data memory, one word every two cycles (read, then
// write). The direction is chosen at start so overlapping blocks behave
// like memmove. abort cancels cleanly between or during word moves;
// words already written are left in place.
module mem_copy
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    mem_copy_if.master  bus
);

    localparam logic [AW-1:0] STEP = AW'(WORD_BYTES);

    state_t        state;
    state_t        state_nxt;

    logic [LW-1:0] cnt;
    logic [AW-1:0] cur_src;
    logic [AW-1:0] cur_dst;
    logic          step_down;
    logic [DW-1:0] data_buf;
    logic [AW-1:0] raddr_q;
    logic [AW-1:0] waddr_q;

    logic          busy_c;
    logic          done_c;
    logic          wen_c;

    logic          desc;
    logic [AW-1:0] start_src;
    logic [AW-1:0] start_dst;

    mem_copy_dir u_dir (
        .src       (bus.src),
        .dst       (bus.dst),
        .len       (bus.len),
        .desc      (desc),
        .start_src (start_src),
        .start_dst (start_dst)
    );

    // State register; reset returns to IDLE at once so wen drops in the
    // same instant reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control outputs. start is honoured only in IDLE and
    // abort only while a word move is in flight.
    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        wen_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.len == '0) ? DONE : READ;
                end
            end
            READ: begin
                busy_c    = 1'b1;
                state_nxt = bus.abort ? IDLE : WRITE;
            end
            WRITE: begin
                busy_c = 1'b1;
                wen_c  = !bus.abort;
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (cnt == LW'(1)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = READ;
                end
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Copy datapath: latch the request on an accepted start, capture the
    // read word, then advance both pointers by one word in the chosen
    // direction after each write. The hold registers keep the last
    // driven bus addresses visible while the ports are not in use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            cur_src   <= '0;
            cur_dst   <= '0;
            step_down <= 1'b0;
            data_buf  <= '0;
            raddr_q   <= '0;
            waddr_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && (bus.len != '0)) begin
                        cnt       <= bus.len;
                        cur_src   <= start_src;
                        cur_dst   <= start_dst;
                        step_down <= desc;
                    end
                end
                READ: begin
                    raddr_q <= cur_src;
                    if (!bus.abort) begin
                        data_buf <= bus.rdata;
                    end
                end
                WRITE: begin
                    waddr_q <= cur_dst;
                    cnt     <= cnt - LW'(1);
                    cur_src <= step_down ? (cur_src - STEP) : (cur_src + STEP);
                    cur_dst <= step_down ? (cur_dst - STEP) : (cur_dst + STEP);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy  = busy_c;
    assign bus.done  = done_c;
    assign bus.wen   = wen_c;
    assign bus.raddr = (state == READ)  ? cur_src : raddr_q;
    assign bus.waddr = (state == WRITE) ? cur_dst : waddr_q;
    assign bus.wdata = data_buf;

endmodule
